// File: rtl/anffl_tex_block_fetch.sv
`default_nettype none
// ============================================================================
// Module   : anffl_tex_block_fetch
// Purpose  : Texel lookup -> 4x4 ETC2 block fetch (2x64-bit beats) with a
//            one-entry block cache, handing the block to the decoder.
// Revision : 1.0  initial release
// ============================================================================
module anffl_tex_block_fetch (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inValid,
    output logic         inReady,
    input  logic [11:0]  inU,
    input  logic [11:0]  inV,
    input  logic [31:0]  inBase,
    input  logic [9:0]   inWidthBlocks,
    input  logic [4:0]   inFormat,
    input  logic         invalidate,
    output logic         memReqValid,
    input  logic         memReqReady,
    output logic [31:0]  memReqAddr,
    input  logic         memRespValid,
    input  logic [63:0]  memRespData,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outData,
    output logic [4:0]   outFormat,
    output logic [1:0]   xTexel,
    output logic [1:0]   yTexel
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_BEAT0 = 3'd2,
        S_BEAT1 = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_nextState;

    logic [19:0]    w_blockIndex;
    logic [31:0]    w_addr;
    logic           w_accept;
    logic           w_hit;
    logic           w_fetching;
    logic           w_unusedBaseBits;

    logic [31:0]    r_addr;
    logic [31:0]    r_tagAddr;
    logic           r_tagValid;
    logic           r_invSeen;
    logic [127:0]   r_data;
    logic [4:0]     r_format;
    logic [1:0]     r_x;
    logic [1:0]     r_y;
    logic           r_inReady;
    logic           r_memReqValid;
    logic           r_outValid;

    assign w_blockIndex     = {10'd0, inV[11:2]} * {10'd0, inWidthBlocks} + {10'd0, inU[11:2]};
    assign w_addr           = {inBase[31:4], 4'b0000} + {8'd0, w_blockIndex, 4'b0000};
    assign w_unusedBaseBits = ^inBase[3:0];
    assign w_accept         = (r_state == S_IDLE) && inValid;
    // A coincident invalidate forces the lookup to miss.
    assign w_hit            = r_tagValid && !invalidate && (r_tagAddr == w_addr);
    assign w_fetching       = (r_state == S_REQ) || (r_state == S_BEAT0) || (r_state == S_BEAT1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (inValid)      w_nextState = w_hit ? S_OUT : S_REQ;
            S_REQ:   if (memReqReady)  w_nextState = S_BEAT0;
            S_BEAT0: if (memRespValid) w_nextState = S_BEAT1;
            S_BEAT1: if (memRespValid) w_nextState = S_OUT;
            S_OUT:   if (outReady)     w_nextState = S_IDLE;
            default:                   w_nextState = S_IDLE;
        endcase
    end

    // r_data doubles as the cache line and the output block register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr        <= 32'd0;
            r_tagAddr     <= 32'd0;
            r_tagValid    <= 1'b0;
            r_invSeen     <= 1'b0;
            r_data        <= 128'd0;
            r_format      <= 5'd0;
            r_x           <= 2'd0;
            r_y           <= 2'd0;
            r_inReady     <= 1'b1;
            r_memReqValid <= 1'b0;
            r_outValid    <= 1'b0;
        end else begin
            r_inReady     <= (w_nextState == S_IDLE);
            r_memReqValid <= (w_nextState == S_REQ);
            r_outValid    <= (w_nextState == S_OUT);

            if (w_accept) begin
                r_addr    <= w_addr;
                r_format  <= inFormat;
                r_x       <= inU[1:0];
                r_y       <= inV[1:0];
                r_invSeen <= 1'b0;
            end else if (w_fetching && invalidate) begin
                r_invSeen <= 1'b1;
            end

            if ((r_state == S_BEAT0) && memRespValid) begin
                r_data[63:0] <= memRespData;
            end

            if ((r_state == S_BEAT1) && memRespValid) begin
                r_data[127:64] <= memRespData;
                r_tagAddr      <= r_addr;
            end

            if (invalidate) begin
                r_tagValid <= 1'b0;
            end else if ((r_state == S_BEAT1) && memRespValid) begin
                r_tagValid <= !r_invSeen;
            end
        end
    end

    assign inReady     = r_inReady;
    assign memReqValid = r_memReqValid;
    assign memReqAddr  = r_addr;
    assign outValid    = r_outValid;
    assign outData     = r_data;
    assign outFormat   = r_format;
    assign xTexel      = r_x;
    assign yTexel      = r_y;

endmodule

`default_nettype wire
